// File: rtl/lfsr_2tap_checker.sv
// rtl/lfsr_2tap_checker.sv - receive-side PRBS checker for a 2-tap XNOR LFSR stream
module lfsr_2tap_checker #(
  parameter int N           = 3,
  parameter int FB_TAP      = 2,
  parameter int LOCK_CNT    = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr_err,
  input  logic             i_din,
  input  logic             i_din_vld,
  output logic             o_locked,
  output logic             o_err,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [31:0]      o_bit_cnt
);

  localparam int SEED_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  state_t            r_state,     w_state;
  logic [N:1]        r_sr,        w_sr;
  logic [SEED_W-1:0] r_seed_cnt,  w_seed_cnt;
  logic [7:0]        r_match_cnt, w_match_cnt;
  logic [7:0]        r_cons_err,  w_cons_err;
  logic              r_err,       w_err;
  logic [ERR_W-1:0]  r_err_cnt,   w_err_cnt;
  logic [31:0]       r_bit_cnt,   w_bit_cnt;

  logic              w_pred;
  logic              w_miss;

  // Local LFSR prediction of the next stream bit and comparison against the received bit
  always_comb begin
    w_pred = ~(r_sr[N] ^ r_sr[FB_TAP]);
    w_miss = (i_din != w_pred);
  end

  // Next-state logic: seeding, lock verification and locked error accounting
  always_comb begin
    w_state     = r_state;
    w_sr        = r_sr;
    w_seed_cnt  = r_seed_cnt;
    w_match_cnt = r_match_cnt;
    w_cons_err  = r_cons_err;
    w_err       = 1'b0;
    w_err_cnt   = r_err_cnt;
    w_bit_cnt   = r_bit_cnt;

    if (i_din_vld) begin
      case (r_state)
        ST_SEED: begin
          w_sr       = {r_sr[N-1:1], i_din};
          w_seed_cnt = r_seed_cnt + 1'b1;
          if (w_seed_cnt == SEED_W'(N)) begin
            w_match_cnt = 8'd0;
            w_state     = ST_VERIFY;
          end
        end

        ST_VERIFY: begin
          // Always follow the received stream so a bad seed resynchronises by itself
          w_sr        = {r_sr[N-1:1], i_din};
          w_match_cnt = w_miss ? 8'd0 : (r_match_cnt + 8'd1);
          if (w_match_cnt == 8'(LOCK_CNT)) begin
            if (&w_sr) begin
              // All-ones is the XNOR lock-up state; a real generator never produces it
              w_seed_cnt = '0;
              w_state    = ST_SEED;
            end else begin
              w_cons_err = 8'd0;
              w_state    = ST_LOCK;
            end
          end
        end

        ST_LOCK: begin
          // Free-running: received errors must not corrupt the local reference
          w_sr      = {r_sr[N-1:1], w_pred};
          w_bit_cnt = (&r_bit_cnt) ? r_bit_cnt : (r_bit_cnt + 32'd1);
          if (w_miss) begin
            w_err      = 1'b1;
            w_err_cnt  = (&r_err_cnt) ? r_err_cnt : (r_err_cnt + 1'b1);
            w_cons_err = r_cons_err + 8'd1;
            if (w_cons_err == 8'(UNLOCK_ERRS)) begin
              w_seed_cnt = '0;
              w_state    = ST_SEED;
            end
          end else begin
            w_cons_err = 8'd0;
          end
        end

        default: begin
          w_seed_cnt = '0;
          w_state    = ST_SEED;
        end
      endcase
    end

    // Clear takes priority over any increment in the same cycle
    if (i_clr_err) begin
      w_err_cnt = '0;
      w_bit_cnt = '0;
    end
  end

  // State and counter registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_SEED;
      r_sr        <= '0;
      r_seed_cnt  <= '0;
      r_match_cnt <= 8'd0;
      r_cons_err  <= 8'd0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_bit_cnt   <= 32'd0;
    end else begin
      r_state     <= w_state;
      r_sr        <= w_sr;
      r_seed_cnt  <= w_seed_cnt;
      r_match_cnt <= w_match_cnt;
      r_cons_err  <= w_cons_err;
      r_err       <= w_err;
      r_err_cnt   <= w_err_cnt;
      r_bit_cnt   <= w_bit_cnt;
    end
  end

  // Outputs come straight from registers, one cycle after the deciding valid bit
  always_comb begin
    o_locked  = (r_state == ST_LOCK);
    o_err     = r_err;
    o_err_cnt = r_err_cnt;
    o_bit_cnt = r_bit_cnt;
  end

endmodule
